// File: rtl/dram_read_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache sitting between the
// core's DRAM request port and the SDRAM controller.
module dram_read_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              data_valid,
  output logic              write_complete,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req_read,
  output logic              mem_req_write,
  output logic [31:0]       mem_data_out,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_data_valid,
  input  logic              mem_write_complete,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_HOLD
  } state_t;

  state_t              state_q;
  logic [LINES-1:0]    valid_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [31:0]         lat_data_q;
  logic [31:0]         data_out_q;
  logic                data_valid_q;
  logic                write_complete_q;
  logic                mem_req_read_q;
  logic                mem_req_write_q;
  logic [15:0]         hit_count_q;
  logic [15:0]         miss_count_q;

  // Tag and data storage carry no reset; the valid vector alone qualifies them.
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  lookup_hit;
  logic                  idle_flush;
  logic                  idle_write;
  logic                  idle_read;
  logic                  wr_hit_we;
  logic                  fill_we;

  assign req_idx  = addr[INDEX_BITS-1:0];
  assign req_tag  = addr[ADDR_W-1:INDEX_BITS];
  assign fill_idx = lat_addr_q[INDEX_BITS-1:0];
  assign fill_tag = lat_addr_q[ADDR_W-1:INDEX_BITS];

  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Flush outranks writes, and writes outrank reads, when several arrive together.
  assign idle_flush = (state_q == ST_IDLE) && flush;
  assign idle_write = (state_q == ST_IDLE) && !flush && req_write;
  assign idle_read  = (state_q == ST_IDLE) && !flush && !req_write && req_read;

  assign wr_hit_we = idle_write && lookup_hit;
  assign fill_we   = (state_q == ST_RD) && mem_data_valid;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= mem_data_in;
      tag_mem[fill_idx]  <= fill_tag;
    end else if (wr_hit_we) begin
      data_mem[req_idx]  <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      valid_q          <= '0;
      lat_addr_q       <= '0;
      lat_data_q       <= '0;
      data_out_q       <= '0;
      data_valid_q     <= 1'b0;
      write_complete_q <= 1'b0;
      mem_req_read_q   <= 1'b0;
      mem_req_write_q  <= 1'b0;
      hit_count_q      <= '0;
      miss_count_q     <= '0;
    end else begin
      data_valid_q     <= 1'b0;
      write_complete_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (idle_flush) begin
            valid_q <= '0;
          end else if (idle_write) begin
            lat_addr_q      <= addr;
            lat_data_q      <= data_in;
            mem_req_write_q <= 1'b1;
            state_q         <= ST_WR;
          end else if (idle_read && lookup_hit) begin
            data_out_q   <= data_mem[req_idx];
            data_valid_q <= 1'b1;
            if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            state_q      <= ST_HOLD;
          end else if (idle_read) begin
            lat_addr_q     <= addr;
            mem_req_read_q <= 1'b1;
            if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            state_q        <= ST_RD;
          end
        end
        ST_RD: begin
          if (mem_data_valid) begin
            valid_q[fill_idx] <= 1'b1;
            data_out_q        <= mem_data_in;
            data_valid_q      <= 1'b1;
            mem_req_read_q    <= 1'b0;
            state_q           <= ST_HOLD;
          end
        end
        ST_WR: begin
          if (mem_write_complete) begin
            write_complete_q <= 1'b1;
            mem_req_write_q  <= 1'b0;
            state_q          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign write_complete = write_complete_q;
  assign mem_addr       = lat_addr_q;
  assign mem_req_read   = mem_req_read_q;
  assign mem_req_write  = mem_req_write_q;
  assign mem_data_out   = lat_data_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_dram_read_cache.sv
// Bench for dram_read_cache: acts as core and SDRAM controller, and checks against
// an abstract cache/backing-memory model (valid/tag/data per line plus a word store).
module tb_dram_read_cache;

  localparam int IB = 6;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          req_read, req_write, flush;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          data_valid, write_complete;
  logic [AW-1:0] mem_addr;
  logic          mem_req_read, mem_req_write;
  logic [31:0]   mem_data_out;
  logic [31:0]   mem_data_in;
  logic          mem_data_valid, mem_write_complete;
  logic [15:0]   hit_count, miss_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] bmem [int unsigned];
  int unsigned m_hits, m_misses;

  always #5 clk = ~clk;

  dram_read_cache #(.INDEX_BITS(IB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .req_read(req_read), .req_write(req_write),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .write_complete(write_complete), .flush(flush), .mem_addr(mem_addr),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_write_complete(mem_write_complete), .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input int unsigned a);
    if (bmem.exists(a)) return bmem[a];
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic check_counters(input string name);
    check({name, "_hits"}, {16'h0, hit_count}, m_hits);
    check({name, "_misses"}, {16'h0, miss_count}, m_misses);
  endtask

  task automatic do_read(input int unsigned a, input int dly);
    int unsigned idx, tg;
    bit          exp_hit;
    logic [31:0] exp_d;
    idx = a % 64;
    tg  = a / 64;
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_d   = exp_hit ? m_data[idx] : mem_val(a);
    @(negedge clk);
    addr = a[AW-1:0];
    req_read = 1'b1;
    @(negedge clk);
    if (exp_hit) begin
      if (m_hits < 16'hFFFF) m_hits++;
      check("hit_dvalid", {31'h0, data_valid}, 1);
      check("hit_data", data_out, exp_d);
      check("hit_no_memreq", {31'h0, mem_req_read}, 0);
    end else begin
      if (m_misses < 16'hFFFF) m_misses++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = exp_d;
      check("miss_memreq", {31'h0, mem_req_read}, 1);
      check("miss_memaddr", {8'h0, mem_addr}, a);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        check("miss_wait_req", {31'h0, mem_req_read}, 1);
        check("miss_wait_dv", {31'h0, data_valid}, 0);
      end
      mem_data_in = exp_d;
      mem_data_valid = 1'b1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      mem_data_in = $urandom;
      check("miss_dvalid", {31'h0, data_valid}, 1);
      check("miss_data", data_out, exp_d);
      check("miss_req_drop", {31'h0, mem_req_read}, 0);
    end
    req_read = 1'b0;
    @(negedge clk);
    check("rd_pulse_end", {31'h0, data_valid}, 0);
    check_counters("rd");
    $display("read  addr=%06h %s data=%08h", a, exp_hit ? "hit " : "miss", exp_d);
  endtask

  task automatic do_write(input int unsigned a, input logic [31:0] d, input int dly);
    int unsigned idx;
    idx = a % 64;
    if (m_valid[idx] && (m_tag[idx] == a / 64)) m_data[idx] = d;
    bmem[a] = d;
    @(negedge clk);
    addr = a[AW-1:0];
    data_in = d;
    req_write = 1'b1;
    @(negedge clk);
    data_in = $urandom;
    check("wr_memreq", {31'h0, mem_req_write}, 1);
    check("wr_memaddr", {8'h0, mem_addr}, a);
    check("wr_memdata", mem_data_out, d);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("wr_wait_req", {31'h0, mem_req_write}, 1);
      check("wr_wait_wc", {31'h0, write_complete}, 0);
    end
    mem_write_complete = 1'b1;
    @(negedge clk);
    mem_write_complete = 1'b0;
    check("wr_complete", {31'h0, write_complete}, 1);
    check("wr_req_drop", {31'h0, mem_req_write}, 0);
    req_write = 1'b0;
    @(negedge clk);
    check("wr_pulse_end", {31'h0, write_complete}, 0);
    check_counters("wr");
    $display("write addr=%06h data=%08h", a, d);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    $display("flush");
  endtask

  initial begin
    int unsigned a;
    int          op;
    rst_n = 1'b0;
    addr = '0; req_read = 1'b0; req_write = 1'b0; flush = 1'b0; data_in = '0;
    mem_data_in = '0; mem_data_valid = 1'b0; mem_write_complete = 1'b0;
    model_reset();
    #12;
    check("rst_dvalid", {31'h0, data_valid}, 0);
    check("rst_wc", {31'h0, write_complete}, 0);
    check("rst_memrd", {31'h0, mem_req_read}, 0);
    check("rst_memwr", {31'h0, mem_req_write}, 0);
    check("rst_dout", data_out, 0);
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Miss then hit, controller answers after 8 cycles
    bmem[32'h41] = 32'hDEADBEEF;
    do_read(32'h41, 8);
    check("tp_miss1", {16'h0, miss_count}, 1);
    do_read(32'h41, 0);
    check("tp_hit1", {16'h0, hit_count}, 1);

    // Conflict eviction on index 1
    do_read(32'h1041, 3);
    do_read(32'h41, 2);
    check("tp_miss3", {16'h0, miss_count}, 3);

    // Write-through hit, then read back
    do_write(32'h41, 32'h12345678, 4);
    do_read(32'h41, 0);

    // Write miss does not allocate
    do_write(32'h2, 32'hCAFEF00D, 1);
    do_read(32'h2, 2);

    // Flush invalidates everything
    do_read(32'h100, 1);
    do_read(32'h101, 1);
    do_read(32'h102, 1);
    do_flush();
    do_read(32'h100, 1);
    do_read(32'h101, 1);
    do_read(32'h102, 1);

    // Asynchronous reset while a miss is outstanding
    @(negedge clk);
    addr = 24'h000041;
    req_read = 1'b1;
    @(negedge clk);
    check("ar_memreq", {31'h0, mem_req_read}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_memreq_drop", {31'h0, mem_req_read}, 0);
    check("ar_dvalid", {31'h0, data_valid}, 0);
    model_reset();
    @(negedge clk);
    req_read = 1'b0;
    check("ar_no_pulse", {31'h0, data_valid}, 0);
    check_counters("ar");
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset during miss");
    do_read(32'h41, 2);

    // Randomised traffic over a small footprint to force hits and conflicts
    for (int n = 0; n < 250; n++) begin
      a  = ($urandom_range(0, 3) * 64) + $urandom_range(0, 7);
      op = $urandom_range(0, 9);
      if (op < 6)      do_read(a, $urandom_range(0, 6));
      else if (op < 9) do_write(a, $urandom, $urandom_range(0, 6));
      else             do_flush();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
